hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 26 ++
 rtl/hazard_ctrl_sat_counter.sv | 33 +++
 rtl/hazard_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: opcodes, hazard FSM encoding, operand-use helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] OP_BUBBLE = 6'b111111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } hz_state_e;

    // Opcodes whose rt field is a source operand rather than a destination.
    function automatic logic op_uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

    function automatic logic op_is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
// Latency: count reflects inc one edge later; async reset clears immediately.
// Backpressure: none.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use / branch-operand stalls, IF flush on redirect, perf counters.
// Latency: zero-cycle combinational detection; branch-after-load holds a second stall cycle.
// Backpressure: stall deasserts PC/IFID write and bubbles ID/EX; stall overrides flush.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       id_op,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_wreg,
    output logic             c_PCWrite,
    output logic             c_IFIDWrite,
    output logic             c_if_flush,
    output logic             c_idex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_e state_q;
    hz_state_e state_d;

    logic match;
    logic load_use;
    logic br_alu;
    logic br_load;
    logic stall;

    always_comb begin
        match = 1'b0;
        if ((id_op != OP_BUBBLE) && (ex_wreg != 5'd0)) begin
            match = (ex_wreg == id_rs) || (op_uses_rt(id_op) && (ex_wreg == id_rt));
        end
        load_use = ex_memread && match;
        br_alu   = op_is_branch(id_op) && ex_regwrite && !ex_memread && match;
        br_load  = op_is_branch(id_op) && ex_memread && match;
    end

    // HOLD ignores all inputs: it only provides the second cycle for a load feeding a branch.
    always_comb begin
        state_d = ST_RUN;
        stall   = 1'b0;
        case (state_q)
            ST_RUN: begin
                stall = load_use || br_alu || br_load;
                if (br_load) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                stall   = 1'b1;
                state_d = ST_RUN;
            end
            default: begin
                stall   = 1'b0;
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        c_PCWrite     = 1'b1;
        c_IFIDWrite   = 1'b1;
        c_idex_bubble = 1'b0;
        c_if_flush    = 1'b0;
        if (stall) begin
            c_PCWrite     = 1'b0;
            c_IFIDWrite   = 1'b0;
            c_idex_bubble = 1'b1;
        end else begin
            c_if_flush = id_branch_taken || id_jump;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (c_if_flush),
        .count (flush_cnt)
    );

endmodule
